// File: rtl/pipe_stage_reg.sv
// Pipeline register between core stages with a valid/ready handshake and a
// two-entry skid buffer. Define PIPE_STAGE_REG_PERF_EN for stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned       WORD_LENGTH = 32,
  parameter int unsigned       NUM_FIELDS  = 6,
  parameter int unsigned       INSTR_FIELD = 2,
  parameter logic [WORD_LENGTH-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned       CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_FIELDS*WORD_LENGTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_FIELDS*WORD_LENGTH-1:0] out_data,
  input  logic                              stall,
  input  logic                              flush
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]              stall_cnt,
  output logic [CNT_WIDTH-1:0]              bubble_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
  typedef logic [NUM_FIELDS-1:0][WORD_LENGTH-1:0] bundle_t;

  state_t  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    in_ready_q, in_ready_d;

  logic accept, consume;
  bundle_t in_bundle;

  assign in_bundle = bundle_t'(in_data);
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready & ~stall;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d              = EMPTY;
      main_d[INSTR_FIELD]  = NOP_INSTR;
      skid_d               = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_bundle;
            state_d = FULL;
          end
        end
        FULL: begin
          if (accept && consume) begin
            main_d = in_bundle;
          end else if (consume) begin
            // Drained entry keeps stale operands but must not look like an instruction
            main_d[INSTR_FIELD] = NOP_INSTR;
            state_d             = EMPTY;
          end else if (accept) begin
            skid_d  = in_bundle;
            state_d = SKID;
          end
        end
        SKID: begin
          if (consume) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Registered ready: decided from the next state, never from out_ready directly
    in_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= EMPTY;
      main_q              <= '0;
      main_q[INSTR_FIELD] <= NOP_INSTR;
      skid_q              <= '0;
      in_ready_q          <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, bubble_cnt_q;
  logic                 stall_inc, bubble_inc;

  assign stall_inc  = out_valid & ~consume & ~flush;
  assign bubble_inc = ~out_valid & out_ready & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (bubble_inc && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
